router_fsm_nch: RTL
===================

ROUTER_FSM_NCH -- requirements
Module: router_fsm_nch

Interface
REQ-001 Parameter NUM_CH, default 3, number of output channels, legal 2..8.
REQ-002 Parameter DATA_W, default 8, header/data byte width, SHALL be >= ADDR_W.
REQ-003 Parameter ADDR_W, default 2, header address field width = data_in[ADDR_W-1:0], SHALL satisfy 2**ADDR_W >= NUM_CH.
REQ-004 Parameter WAIT_MAX, default 32, WAIT_EMPTY timeout in cycles; 0 disables timeout.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 resetn  in  1  synchronous active-low reset.
REQ-007 packet_valid  in  1  packet in progress on data_in.
REQ-008 data_in  in  DATA_W  header byte when in DECODE.
REQ-009 fifo_full  in  1  full flag of currently selected FIFO.
REQ-010 fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
REQ-011 soft_reset  in  NUM_CH  per-channel soft reset requests.
REQ-012 parity_done, low_packet_valid  in  1 each  register-block status.
REQ-013 detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy  out  1 each  state decodes.
REQ-014 dest_sel  out  ADDR_W  latched destination channel.
REQ-015 drop_state  out  1  packet being discarded.
REQ-016 addr_err, wait_timeout  out  1 each  single-cycle error pulses.

Function
REQ-017 States SHALL be DECODE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, LOAD_PARITY, FIFO_FULL, LOAD_AFTER_FULL, CHECK_PARITY, DROP; registered present state, combinational next state.
REQ-018 dest_sel SHALL load data_in[ADDR_W-1:0] on every clock where state is DECODE; hold otherwise.
REQ-019 DECODE: packet_valid and addr<NUM_CH and fifo_empty[addr] -> LOAD_FIRST; packet_valid and addr<NUM_CH and not empty -> WAIT_EMPTY; packet_valid and addr>=NUM_CH -> DROP with addr_err pulsed that cycle; else stay.
REQ-020 WAIT_EMPTY: fifo_empty[dest_sel] -> LOAD_FIRST; else if WAIT_MAX!=0 and wait counter == WAIT_MAX-1 -> DROP with wait_timeout pulsed; else stay.
REQ-021 Wait counter SHALL clear on every state other than WAIT_EMPTY and increment each WAIT_EMPTY cycle, saturating; width $clog2(WAIT_MAX+1).
REQ-022 Empty test takes priority over timeout in the same cycle.
REQ-023 LOAD_FIRST -> LOAD_DATA unconditionally.
REQ-024 LOAD_DATA: fifo_full -> FIFO_FULL; else !packet_valid -> LOAD_PARITY; else stay.
REQ-025 FIFO_FULL: !fifo_full -> LOAD_AFTER_FULL; else stay.
REQ-026 LOAD_AFTER_FULL: parity_done -> DECODE; else low_packet_valid -> LOAD_PARITY; else -> LOAD_DATA.
REQ-027 LOAD_PARITY -> CHECK_PARITY; CHECK_PARITY: fifo_full -> FIFO_FULL, else DECODE.
REQ-028 DROP: packet_valid -> stay; else DECODE; no writes in DROP.
REQ-029 soft_reset[dest_sel] high in any non-DECODE state SHALL force DECODE next cycle, overriding next-state logic; soft_reset of other channels ignored.
REQ-030 Decodes: detect_add=DECODE; lfd_state=LOAD_FIRST; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL; rst_int_reg=CHECK_PARITY; drop_state=DROP.
REQ-031 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY only.
REQ-032 busy SHALL be 1 in WAIT_EMPTY, LOAD_FIRST, LOAD_PARITY, FIFO_FULL, LOAD_AFTER_FULL, CHECK_PARITY; 0 in DECODE, LOAD_DATA, DROP.
REQ-033 Unreachable state encodings SHALL return to DECODE next cycle.

Reset
REQ-034 resetn low at a rising edge SHALL set state DECODE, dest_sel 0, wait counter 0; highest priority, including mid-packet.
REQ-035 Outputs after reset: detect_add 1, all other 1-bit outputs 0, dest_sel 0.

Structure
REQ-036 State enumeration and encoding constants SHALL live in shared package router_pkg.
REQ-037 Wait counter SHALL be sub-module router_wait_timer (enable, clear, expire).

Verification
REQ-038 NUM_CH=3, header 0x01, fifo_empty=3'b111, 4 payload bytes, packet_valid drop -> DECODE,LOAD_FIRST,LOAD_DATAx4,LOAD_PARITY,CHECK_PARITY,DECODE; dest_sel=1.
REQ-039 Header 0x03 with NUM_CH=3 -> addr_err 1 cycle, drop_state until packet_valid low, write_enb_reg never 1.
REQ-040 Header 0x02, fifo_empty[2]=0 for 40 cycles, WAIT_MAX=32 -> wait_timeout on 32nd WAIT_EMPTY cycle, then DROP.
REQ-041 fifo_full high 3 cycles in LOAD_DATA -> FIFO_FULL x3, LOAD_AFTER_FULL; parity_done=1 -> DECODE.
REQ-042 dest_sel=0 in LOAD_DATA: soft_reset=3'b010 -> no effect; soft_reset=3'b001 -> DECODE next cycle.
REQ-043 resetn low during FIFO_FULL -> DECODE, dest_sel 0, detect_add 1 next cycle.

Source files
------------

// File: rtl/router_pkg.sv
// router_pkg -- shared definitions for the packet router controller.
//   state_t     : controller state enumeration (4-bit encoding, 9 legal codes)
//   wait_cnt_w  : width of the WAIT_EMPTY timeout counter for a given limit
package router_pkg;

  typedef enum logic [3:0] {
    ST_DECODE          = 4'd0,
    ST_WAIT_EMPTY      = 4'd1,
    ST_LOAD_FIRST      = 4'd2,
    ST_LOAD_DATA       = 4'd3,
    ST_LOAD_PARITY     = 4'd4,
    ST_FIFO_FULL       = 4'd5,
    ST_LOAD_AFTER_FULL = 4'd6,
    ST_CHECK_PARITY    = 4'd7,
    ST_DROP            = 4'd8
  } state_t;

  localparam int STATE_W = 4;

  // A limit of 0 disables the timeout; the counter still needs one bit.
  function automatic int wait_cnt_w(input int wait_max);
    return (wait_max > 0) ? $clog2(wait_max + 1) : 1;
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// router_wait_timer -- cycle counter for the WAIT_EMPTY timeout.
//   clk, resetn : clock, synchronous active-low reset
//   enable      : count this cycle (controller is in WAIT_EMPTY)
//   clear       : zero the counter (controller is anywhere else)
//   expire      : high while enabled and the counter sits at WAIT_MAX-1,
//                 i.e. on the WAIT_MAX-th consecutive waiting cycle
module router_wait_timer
  import router_pkg::*;
#(
  parameter int WAIT_MAX = 32
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CNT_W = wait_cnt_w(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WAIT_MAX);

  logic [CNT_W-1:0] cnt_reg;

  // Saturates at WAIT_MAX so a long wait can never wrap back onto CNT_LAST.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != CNT_SAT)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign expire = (WAIT_MAX != 0) && enable && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/router_fsm_nch.sv
// router_fsm_nch -- packet router control FSM for NUM_CH output channels.
//   clk, resetn        : clock, synchronous active-low reset
//   packet_valid       : packet in progress on data_in
//   data_in            : header byte (address in the low ADDR_W bits) in DECODE
//   fifo_full          : full flag of the selected FIFO
//   fifo_empty         : per-channel FIFO empty flags
//   soft_reset         : per-channel soft reset requests
//   parity_done        : parity byte already written
//   low_packet_valid   : packet ended while the FIFO was full
//   detect_add .. busy : decodes of the present state
//   dest_sel           : destination channel latched from the header
//   drop_state         : packet is being discarded
//   addr_err           : one-cycle pulse, header addresses a missing channel
//   wait_timeout       : one-cycle pulse, destination never drained in time
module router_fsm_nch
  import router_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int WAIT_MAX = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              packet_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              parity_done,
  input  logic              low_packet_valid,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              write_enb_reg,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [ADDR_W-1:0] dest_sel,
  output logic              drop_state,
  output logic              addr_err,
  output logic              wait_timeout
);

  localparam int NSEL = 1 << ADDR_W;
  localparam logic [ADDR_W:0] NUM_CH_V = (ADDR_W + 1)'(NUM_CH);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] dest_sel_reg;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_ok;
  logic              soft_hit;
  logic              wait_expire;
  logic              unused_data;

  // Flags widened to the full address space so any ADDR_W value indexes
  // safely; channels that do not exist read as not-empty / no soft reset.
  logic [NSEL-1:0]   empty_ext;
  logic [NSEL-1:0]   soft_ext;

  for (genvar gi = 0; gi < NSEL; gi++) begin : g_ext
    if (gi < NUM_CH) begin : g_real
      assign empty_ext[gi] = fifo_empty[gi];
      assign soft_ext[gi]  = soft_reset[gi];
    end else begin : g_pad
      assign empty_ext[gi] = 1'b0;
      assign soft_ext[gi]  = 1'b0;
    end
  end

  assign hdr_addr    = data_in[ADDR_W-1:0];
  assign unused_data = ^data_in;
  assign hdr_ok      = {1'b0, hdr_addr} < NUM_CH_V;
  assign soft_hit    = (state_reg != ST_DECODE) && soft_ext[dest_sel_reg];

  router_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .resetn (resetn),
    .enable (state_reg == ST_WAIT_EMPTY),
    .clear  (state_reg != ST_WAIT_EMPTY),
    .expire (wait_expire)
  );

  always_comb begin
    state_next   = state_reg;
    addr_err     = 1'b0;
    wait_timeout = 1'b0;
    case (state_reg)
      ST_DECODE: begin
        if (packet_valid) begin
          if (hdr_ok) begin
            state_next = empty_ext[hdr_addr] ? ST_LOAD_FIRST : ST_WAIT_EMPTY;
          end else begin
            state_next = ST_DROP;
            addr_err   = 1'b1;
          end
        end
      end
      ST_WAIT_EMPTY: begin
        // Draining wins over a timeout landing in the same cycle.
        if (empty_ext[dest_sel_reg]) begin
          state_next = ST_LOAD_FIRST;
        end else if (wait_expire) begin
          state_next   = ST_DROP;
          wait_timeout = !soft_hit;
        end
      end
      ST_LOAD_FIRST:      state_next = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        if (fifo_full)          state_next = ST_FIFO_FULL;
        else if (!packet_valid) state_next = ST_LOAD_PARITY;
      end
      ST_FIFO_FULL: begin
        if (!fifo_full) state_next = ST_LOAD_AFTER_FULL;
      end
      ST_LOAD_AFTER_FULL: begin
        if (parity_done)           state_next = ST_DECODE;
        else if (low_packet_valid) state_next = ST_LOAD_PARITY;
        else                       state_next = ST_LOAD_DATA;
      end
      ST_LOAD_PARITY:     state_next = ST_CHECK_PARITY;
      ST_CHECK_PARITY:    state_next = fifo_full ? ST_FIFO_FULL : ST_DECODE;
      ST_DROP: begin
        if (!packet_valid) state_next = ST_DECODE;
      end
      default:            state_next = ST_DECODE;
    endcase
    // A soft reset of the active channel aborts whatever is in flight.
    if (soft_hit) state_next = ST_DECODE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= ST_DECODE;
      dest_sel_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE) dest_sel_reg <= hdr_addr;
    end
  end

  assign dest_sel      = dest_sel_reg;
  assign detect_add    = (state_reg == ST_DECODE);
  assign lfd_state     = (state_reg == ST_LOAD_FIRST);
  assign ld_state      = (state_reg == ST_LOAD_DATA);
  assign laf_state     = (state_reg == ST_LOAD_AFTER_FULL);
  assign full_state    = (state_reg == ST_FIFO_FULL);
  assign rst_int_reg   = (state_reg == ST_CHECK_PARITY);
  assign drop_state    = (state_reg == ST_DROP);
  assign write_enb_reg = (state_reg == ST_LOAD_DATA) ||
                         (state_reg == ST_LOAD_AFTER_FULL) ||
                         (state_reg == ST_LOAD_PARITY);
  assign busy          = (state_reg == ST_WAIT_EMPTY) ||
                         (state_reg == ST_LOAD_FIRST) ||
                         (state_reg == ST_LOAD_PARITY) ||
                         (state_reg == ST_FIFO_FULL) ||
                         (state_reg == ST_LOAD_AFTER_FULL) ||
                         (state_reg == ST_CHECK_PARITY);

endmodule
